// File: rtl/f32_vrddata_drain_if.sv
`default_nettype none
// ============================================================================
// Module      : f32_vrddata_drain_if
// Description : Bundle of the per-port read request, slot-pointer, delay-slot
//               array and drained read-data signals of the read-data drain.
//               The master side issues reads and supplies the slot array; the
//               slave side (the drain) returns slot pointers and read data.
// Revision    : 1.0 - initial release
// ============================================================================
interface f32_vrddata_drain_if #(
  parameter int WIDTH      = 256,
  parameter int NUMRDPT    = 4,
  parameter int READ_DELAY = 30,
  parameter int BITRDLY    = 5
);
  logic [NUMRDPT-1:0]                             read;
  logic [NUMRDPT-1:0][BITRDLY-1:0]                rdptr;
  logic [NUMRDPT-1:0][READ_DELAY-1:0][WIDTH-1:0]  vrddata;
  logic [NUMRDPT-1:0]                             rd_vld;
  logic [NUMRDPT-1:0][WIDTH-1:0]                  rd_dout;
  logic [NUMRDPT-1:0][BITRDLY:0]                  rd_cnt;

  modport master (
    output read,
    output vrddata,
    input  rdptr,
    input  rd_vld,
    input  rd_dout,
    input  rd_cnt
  );

  modport slave (
    input  read,
    input  vrddata,
    output rdptr,
    output rd_vld,
    output rd_dout,
    output rd_cnt
  );
endinterface
`default_nettype wire

// File: rtl/f32_vrddata_drain.sv
`default_nettype none
// ============================================================================
// Module      : f32_vrddata_drain
// Description : Fixed-latency read-data drain. Every read issued on a port is
//               handed the next slot of that port's delay-slot array; exactly
//               READ_DELAY cycles later the slot contents are presented on
//               rd_dout with a one-cycle rd_vld, slots draining in allocation
//               order. Ports are fully independent. READ_DELAY must be >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
module f32_vrddata_drain #(
  parameter int WIDTH      = 256,
  parameter int NUMRDPT    = 4,
  parameter int READ_DELAY = 30,
  parameter int BITRDLY    = 5
) (
  input  wire logic           clk,
  input  wire logic           rst,
  f32_vrddata_drain_if.slave  bus
);

  // Highest slot index; pointers wrap from here back to slot 0.
  localparam logic [BITRDLY-1:0] c_LAST_SLOT = BITRDLY'(READ_DELAY - 1);
  localparam logic [BITRDLY-1:0] c_PTR_ONE   = BITRDLY'(1);
  localparam logic [BITRDLY:0]   c_CNT_ONE   = (BITRDLY + 1)'(1);

  for (genvar p = 0; p < NUMRDPT; p++) begin : g_port
    // Write/read slot pointers for this port.
    logic [BITRDLY-1:0]    r_wptr;
    logic [BITRDLY-1:0]    r_rptr;
    // Valid pipeline: READ_DELAY-1 register stages, r_vld is the final stage.
    logic [READ_DELAY-2:0] r_vpipe;
    logic                  r_vld;
    logic [WIDTH-1:0]      r_dout;
    logic [BITRDLY:0]      r_cnt;

    logic                  w_read;
    logic                  w_drain;
    logic [BITRDLY-1:0]    w_wptr_nxt;
    logic [BITRDLY-1:0]    w_rptr_nxt;

    assign w_read     = bus.read[p];
    // A read reaching the last register stage is delivered on the next edge.
    assign w_drain    = r_vpipe[READ_DELAY-2];
    assign w_wptr_nxt = (r_wptr == c_LAST_SLOT) ? '0 : r_wptr + c_PTR_ONE;
    assign w_rptr_nxt = (r_rptr == c_LAST_SLOT) ? '0 : r_rptr + c_PTR_ONE;

    // Allocate the next slot to every accepted read.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_wptr <= '0;
      end else if (w_read) begin
        r_wptr <= w_wptr_nxt;
      end
    end

    // Shift read requests through the fixed-latency valid pipeline.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vpipe <= '0;
        r_vld   <= 1'b0;
      end else begin
        r_vpipe <= (r_vpipe << 1) | (READ_DELAY - 1)'(w_read);
        r_vld   <= w_drain;
      end
    end

    // Capture the oldest slot when its read matures; hold data otherwise.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_dout <= '0;
        r_rptr <= '0;
      end else if (w_drain) begin
        r_dout <= bus.vrddata[p][r_rptr];
        r_rptr <= w_rptr_nxt;
      end
    end

    // Outstanding reads: a read stays counted through its rd_vld cycle, so a
    // port issuing every cycle settles at exactly READ_DELAY.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
      end else begin
        case ({w_read, r_vld})
          2'b10:   r_cnt <= r_cnt + c_CNT_ONE;
          2'b01:   r_cnt <= r_cnt - c_CNT_ONE;
          default: r_cnt <= r_cnt;
        endcase
      end
    end

    assign bus.rdptr[p]   = r_wptr;
    assign bus.rd_vld[p]  = r_vld;
    assign bus.rd_dout[p] = r_dout;
    assign bus.rd_cnt[p]  = r_cnt;
  end

endmodule
`default_nettype wire

// File: tb/tb_f32_vrddata_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_f32_vrddata_drain
// Description : Self-checking bench for f32_vrddata_drain. A history-based
//               reference model derives every output from the read/reset
//               history; directed scenarios pin the model with literal values
//               and a randomized phase exercises mixed traffic and resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_f32_vrddata_drain;
  localparam int WIDTH = 256;
  localparam int NP    = 4;
  localparam int RD    = 30;
  localparam int BR    = 5;
  localparam int MAXC  = 4000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  f32_vrddata_drain_if #(.WIDTH(WIDTH), .NUMRDPT(NP), .READ_DELAY(RD), .BITRDLY(BR)) bus ();

  f32_vrddata_drain #(.WIDTH(WIDTH), .NUMRDPT(NP), .READ_DELAY(RD), .BITRDLY(BR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit hold_data;

  // Model history: accepted reads and allocated slot per cycle.
  bit [NP-1:0] eff_rd  [MAXC];
  int          slot_at [MAXC][NP];
  int          last_rst = -1;
  bit          prev_rst = 1'b1;
  int          nreads  [NP];
  logic [WIDTH-1:0] cap      [NP];
  logic [WIDTH-1:0] exp_dout [NP];

  task automatic chk(input string name, input int p,
                     input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s port %0d cycle %0d: got %0h expected %0h", name, p, cyc, act, exp);
    end
  endtask

  // Reference model compare, once per cycle with inputs stable.
  always @(negedge clk) begin
    int ptr, lo, ecnt, j;
    bit v;
    if (cyc < MAXC) begin
      for (int p = 0; p < NP; p++) begin
        ptr = nreads[p] % RD;
        if (cyc > 0) begin
          lo   = (cyc - RD > last_rst + 1) ? cyc - RD : last_rst + 1;
          ecnt = 0;
          for (int k = lo; k < cyc; k++) ecnt += int'(eff_rd[k][p]);
          v = (cyc - RD > last_rst) && eff_rd[cyc-RD][p];
          if (prev_rst) exp_dout[p] = '0;
          else if (v)   exp_dout[p] = cap[p];
          chk("rdptr",   p, WIDTH'(bus.rdptr[p]),  WIDTH'(ptr));
          chk("rd_cnt",  p, WIDTH'(bus.rd_cnt[p]), WIDTH'(ecnt));
          chk("rd_vld",  p, WIDTH'(bus.rd_vld[p]), WIDTH'(v));
          chk("rd_dout", p, bus.rd_dout[p],        exp_dout[p]);
        end
        eff_rd[cyc][p]  = bus.read[p] && !rst;
        slot_at[cyc][p] = ptr;
        // The read maturing next cycle takes this cycle's slot contents.
        j = cyc + 1 - RD;
        if (!rst && j > last_rst && j >= 0 && eff_rd[j][p])
          cap[p] = bus.vrddata[p][slot_at[j][p]];
        if (rst) nreads[p] = 0;
        else     nreads[p] += int'(eff_rd[cyc][p]);
      end
      if (rst) last_rst = cyc;
      prev_rst = rst;
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (!hold_data) begin
      for (int n = 0; n < 8; n++) begin
        int p, s;
        p = $urandom_range(0, NP - 1);
        s = $urandom_range(0, RD - 1);
        for (int w = 0; w < WIDTH / 32; w++) bus.vrddata[p][s][w*32 +: 32] = $urandom;
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int pct;
    rst = 1'b1;
    bus.read = '0;
    bus.vrddata = '0;
    hold_data = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    for (int p = 0; p < NP; p++) begin
      chk("lit_rst_vld",  p, WIDTH'(bus.rd_vld[p]), '0);
      chk("lit_rst_cnt",  p, WIDTH'(bus.rd_cnt[p]), '0);
      chk("lit_rst_ptr",  p, WIDTH'(bus.rdptr[p]),  '0);
      chk("lit_rst_dout", p, bus.rd_dout[p],        '0);
    end

    // Single read on port 0
    step();
    bus.vrddata[0][0] = 256'hA5;
    bus.read[0] = 1'b1;
    chk("lit_single_ptr", 0, WIDTH'(bus.rdptr[0]), '0);
    step();
    bus.read[0] = 1'b0;
    chk("lit_single_cnt1", 0, WIDTH'(bus.rd_cnt[0]), WIDTH'(1));
    repeat (28) step();
    chk("lit_single_novld", 0, WIDTH'(bus.rd_vld[0]), '0);
    step();
    chk("lit_single_vld",  0, WIDTH'(bus.rd_vld[0]), WIDTH'(1));
    chk("lit_single_dout", 0, bus.rd_dout[0],        256'hA5);
    chk("lit_single_cnt2", 0, WIDTH'(bus.rd_cnt[0]), WIDTH'(1));
    step();
    chk("lit_single_cnt0", 0, WIDTH'(bus.rd_cnt[0]), '0);
    chk("lit_single_hold", 0, bus.rd_dout[0],        256'hA5);

    // 64 back-to-back reads on port 1, slot k holds k
    pulse_reset();
    for (int k = 0; k < RD; k++) bus.vrddata[1][k] = WIDTH'(k);
    bus.read[1] = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i == 40) begin
        chk("lit_burst_ptr",  1, WIDTH'(bus.rdptr[1]),  WIDTH'(10));
        chk("lit_burst_cnt",  1, WIDTH'(bus.rd_cnt[1]), WIDTH'(30));
        chk("lit_burst_vld",  1, WIDTH'(bus.rd_vld[1]), WIDTH'(1));
        chk("lit_burst_dout", 1, bus.rd_dout[1],        WIDTH'(10));
      end
      step();
    end
    bus.read[1] = 1'b0;
    repeat (RD + 5) step();

    // All ports read together
    pulse_reset();
    for (int p = 0; p < NP; p++) bus.vrddata[p][0] = WIDTH'(256 + p);
    bus.read = '1;
    step();
    bus.read = '0;
    repeat (RD - 1) step();
    for (int p = 0; p < NP; p++) begin
      chk("lit_all_vld",  p, WIDTH'(bus.rd_vld[p]), WIDTH'(1));
      chk("lit_all_dout", p, bus.rd_dout[p],        WIDTH'(256 + p));
    end
    step();

    // Reset in flight discards outstanding reads
    pulse_reset();
    for (int i = 0; i <= 60; i++) begin
      bus.read = (i == 0 || i == 2 || i == 5) ? '1 : '0;
      rst = (i == 20);
      if (i == 21) begin
        for (int p = 0; p < NP; p++) begin
          chk("lit_flush_cnt",  p, WIDTH'(bus.rd_cnt[p]), '0);
          chk("lit_flush_ptr",  p, WIDTH'(bus.rdptr[p]),  '0);
          chk("lit_flush_dout", p, bus.rd_dout[p],        '0);
        end
      end
      step();
    end

    // Randomized traffic with varying rates and occasional resets
    hold_data = 1'b0;
    pct = 50;
    for (int i = 0; i < 2000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 3))
          0:       pct = 10;
          1:       pct = 50;
          2:       pct = 90;
          default: pct = 100;
        endcase
      end
      for (int p = 0; p < NP; p++) bus.read[p] = ($urandom_range(0, 99) < pct);
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    bus.read = '0;
    rst = 1'b0;
    repeat (RD + 5) step();

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end
endmodule
`default_nettype wire
